rx_core_param: RTL and testbench

Parametrised successor receive core for the UART datapath. Oversampled serial-to-parallel receiver with configurable data width, parity, bit order and stop-bit count, plus an inline word FIFO. Counts and discards framing and parity errors, and flags inter-frame idle gaps. Sits under UartCore next to the baud generator, which supplies AcqSig_i.

---
 rtl/rx_core_param_if.sv | 29 ++
 rtl/rx_core_param.sv | 267 ++++++++++++++++++++++++++
 tb/tb_rx_core_param.sv | 244 ++++++++++++++++++++++++
 3 files changed

// File: rtl/rx_core_param_if.sv
`default_nettype none
// ============================================================================
// Interface : rx_core_param_if
// Brief     : Receive-FIFO read side of rx_core_param (strobes, data, status).
// Revision  : 1.0 - initial release
// ============================================================================
interface rx_core_param_if #(
    parameter int DATA_W  = 8,
    parameter int FIFO_AW = 6
);
    logic                n_Rd_i;
    logic                n_Clr_i;
    logic [DATA_W-1:0]   Data_o;
    logic                p_Empty_o;
    logic                p_Full_o;
    logic                p_Over_o;
    logic [FIFO_AW:0]    FifoLevel_o;

    modport master (
        output n_Rd_i, n_Clr_i,
        input  Data_o, p_Empty_o, p_Full_o, p_Over_o, FifoLevel_o
    );

    modport slave (
        input  n_Rd_i, n_Clr_i,
        output Data_o, p_Empty_o, p_Full_o, p_Over_o, FifoLevel_o
    );
endinterface
`default_nettype wire

// File: rtl/rx_core_param.sv
`default_nettype none
// ============================================================================
// Module   : rx_core_param
// Brief    : Oversampled UART receiver with parity/stop checking, saturating
//            error counters, idle-gap detection and an inline word FIFO.
//            Build option RX_MAJORITY_VOTE_EN: 2-of-3 vote around mid-bit.
// Revision : 1.0 - initial release
// ============================================================================
module rx_core_param #(
    parameter int DATA_W  = 8,
    parameter int OVS     = 16,
    parameter int FIFO_AW = 6
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                p_Enable_i,
    input  logic                AcqSig_i,
    input  logic                Rx_i,
    input  logic                p_ParityEnable_i,
    input  logic                ParityMethod_i,
    input  logic                p_BigEnd_i,
    input  logic                StopBits_i,
    input  logic [7:0]          IdleGapBits_i,
    rx_core_param_if.slave      fifoBus,
    output logic                p_ParityErr_o,
    output logic                p_FrameErr_o,
    output logic [7:0]          ParityErrorNum_o,
    output logic [7:0]          FrameErrorNum_o,
    output logic                p_IdleGap_o
);
    localparam int TC_W    = $clog2(OVS);
    localparam int BC_W    = $clog2(DATA_W);
    localparam int C_DEPTH = 1 << FIFO_AW;
    localparam logic [TC_W-1:0]  c_TC_END  = TC_W'(OVS - 1);
    localparam logic [TC_W-1:0]  c_TC_MID  = TC_W'(OVS / 2 - 1);
    localparam logic [BC_W-1:0]  c_BC_LAST = BC_W'(DATA_W - 1);
    localparam logic [FIFO_AW:0] c_FULL    = (FIFO_AW + 1)'(C_DEPTH);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } state_t;

    state_t              r_state, w_nextState;
    logic                r_rxMeta, r_rxs;
    logic [TC_W-1:0]     r_tc;
    logic [BC_W-1:0]     r_bitCnt, w_bitIdx;
    logic                r_stopIdx;
    logic [DATA_W-1:0]   r_shift;
    logic                r_parErr, r_frameErr;
    logic                r_cfgParity, r_cfgOdd, r_cfgBigEnd, r_cfgTwoStop;
    logic                r_done, r_doneFe, r_donePe;
    logic [7:0]          r_parNum, r_frameNum;
    logic                r_gapArmed, r_gapPulse;
    logic [TC_W-1:0]     r_gapTc;
    logic [7:0]          r_gapBits;
    logic [DATA_W-1:0]   r_mem [C_DEPTH];
    logic [FIFO_AW-1:0]  r_wrPtr, r_rdPtr;
    logic [FIFO_AW:0]    r_level;
    logic [DATA_W-1:0]   r_dataOut;
    logic                r_over;
    logic                w_active, w_sample, w_bit, w_bitEnd, w_lastStop;
    logic                w_empty, w_full, w_push, w_rdEn, w_wrEn;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rxMeta <= 1'b1;
            r_rxs    <= 1'b1;
        end else begin
            r_rxMeta <= Rx_i;
            r_rxs    <= r_rxMeta;
        end
    end

    assign w_active = p_Enable_i & AcqSig_i;
    assign w_bitEnd = (r_tc == c_TC_END);
    assign w_bitIdx = r_cfgBigEnd ? (c_BC_LAST - r_bitCnt) : r_bitCnt;

`ifdef RX_MAJORITY_VOTE_EN
    logic r_vote0, r_vote1;
    assign w_sample = (r_tc == TC_W'(OVS / 2));
    assign w_bit    = (r_vote0 & r_vote1) | (r_vote0 & r_rxs) | (r_vote1 & r_rxs);
    always_ff @(posedge clk) begin
        if (rst) begin
            r_vote0 <= 1'b1;
            r_vote1 <= 1'b1;
        end else if (w_active) begin
            if (r_tc == TC_W'(OVS / 2 - 2)) r_vote0 <= r_rxs;
            if (r_tc == c_TC_MID)           r_vote1 <= r_rxs;
        end
    end
`else
    assign w_sample = (r_tc == c_TC_MID);
    assign w_bit    = r_rxs;
`endif

    // The last stop decision returns to IDLE mid-bit so the next start edge is caught early.
    assign w_lastStop = w_active && (r_state == S_STOP) && w_sample && (!r_cfgTwoStop || r_stopIdx);

    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_nextState;
    end

    always_comb begin
        w_nextState = r_state;
        if (!p_Enable_i) begin
            w_nextState = S_IDLE;
        end else if (AcqSig_i) begin
            case (r_state)
                S_IDLE:   if (!r_rxs) w_nextState = S_START;
                S_START:  if (w_sample && w_bit) w_nextState = S_IDLE;
                          else if (w_bitEnd)     w_nextState = S_DATA;
                S_DATA:   if (w_bitEnd && r_bitCnt == c_BC_LAST)
                              w_nextState = r_cfgParity ? S_PARITY : S_STOP;
                S_PARITY: if (w_bitEnd) w_nextState = S_STOP;
                S_STOP:   if (w_lastStop) w_nextState = S_IDLE;
                default:  w_nextState = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_tc         <= '0;
            r_bitCnt     <= '0;
            r_stopIdx    <= 1'b0;
            r_shift      <= '0;
            r_parErr     <= 1'b0;
            r_frameErr   <= 1'b0;
            r_cfgParity  <= 1'b0;
            r_cfgOdd     <= 1'b0;
            r_cfgBigEnd  <= 1'b0;
            r_cfgTwoStop <= 1'b0;
            r_done       <= 1'b0;
            r_doneFe     <= 1'b0;
            r_donePe     <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (w_active) begin
                if (r_state == S_IDLE) begin
                    if (!r_rxs) begin
                        r_tc         <= '0;
                        r_bitCnt     <= '0;
                        r_stopIdx    <= 1'b0;
                        r_parErr     <= 1'b0;
                        r_frameErr   <= 1'b0;
                        r_cfgParity  <= p_ParityEnable_i;
                        r_cfgOdd     <= ParityMethod_i;
                        r_cfgBigEnd  <= p_BigEnd_i;
                        r_cfgTwoStop <= StopBits_i;
                    end
                end else begin
                    r_tc <= w_bitEnd ? '0 : r_tc + 1'b1;
                    if (r_state == S_DATA) begin
                        if (w_sample) r_shift[w_bitIdx] <= w_bit;
                        if (w_bitEnd) r_bitCnt <= r_bitCnt + 1'b1;
                    end
                    if (r_state == S_PARITY && w_sample)
                        r_parErr <= ((^r_shift) ^ w_bit) != r_cfgOdd;
                    if (r_state == S_STOP) begin
                        if (w_sample && !w_bit) r_frameErr <= 1'b1;
                        if (w_bitEnd)           r_stopIdx  <= 1'b1;
                    end
                    if (w_lastStop) begin
                        r_done   <= 1'b1;
                        r_doneFe <= r_frameErr | ~w_bit;
                        r_donePe <= r_parErr;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_parNum   <= '0;
            r_frameNum <= '0;
        end else if (r_done) begin
            if (r_donePe && r_parNum != 8'hFF)   r_parNum   <= r_parNum + 8'd1;
            if (r_doneFe && r_frameNum != 8'hFF) r_frameNum <= r_frameNum + 8'd1;
        end
    end

    // Gap timing is anchored on the final stop decision, not on the bit grid.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_gapArmed <= 1'b0;
            r_gapPulse <= 1'b0;
            r_gapTc    <= '0;
            r_gapBits  <= '0;
        end else begin
            r_gapPulse <= 1'b0;
            if (w_lastStop) begin
                r_gapArmed <= 1'b1;
                r_gapTc    <= '0;
                r_gapBits  <= '0;
            end else if (w_active && r_state == S_IDLE) begin
                if (!r_rxs) begin
                    r_gapTc   <= '0;
                    r_gapBits <= '0;
                end else if (r_gapArmed && IdleGapBits_i != 8'd0) begin
                    r_gapTc <= (r_gapTc == c_TC_END) ? '0 : r_gapTc + 1'b1;
                    if (r_gapTc == c_TC_END) begin
                        r_gapBits <= r_gapBits + 8'd1;
                        if (({1'b0, r_gapBits} + 9'd1) >= {1'b0, IdleGapBits_i}) begin
                            r_gapPulse <= 1'b1;
                            r_gapArmed <= 1'b0;
                        end
                    end
                end
            end
        end
    end

    assign w_empty = (r_level == '0);
    assign w_full  = (r_level == c_FULL);
    assign w_push  = r_done & ~r_doneFe & ~r_donePe;
    assign w_rdEn  = ~fifoBus.n_Rd_i & ~w_empty;
    assign w_wrEn  = w_push & (~w_full | w_rdEn);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wrPtr   <= '0;
            r_rdPtr   <= '0;
            r_level   <= '0;
            r_over    <= 1'b0;
            r_dataOut <= '0;
        end else if (!fifoBus.n_Clr_i) begin
            r_wrPtr <= '0;
            r_rdPtr <= '0;
            r_level <= '0;
            r_over  <= 1'b0;
        end else begin
            if (w_push && !w_wrEn) r_over <= 1'b1;
            if (w_rdEn) begin
                r_dataOut <= r_mem[r_rdPtr];
                r_rdPtr   <= r_rdPtr + 1'b1;
            end
            if (w_wrEn) r_wrPtr <= r_wrPtr + 1'b1;
            case ({w_wrEn, w_rdEn})
                2'b10:   r_level <= r_level + 1'b1;
                2'b01:   r_level <= r_level - 1'b1;
                default: r_level <= r_level;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_wrEn && fifoBus.n_Clr_i) r_mem[r_wrPtr] <= r_shift;
    end

    assign fifoBus.Data_o      = r_dataOut;
    assign fifoBus.p_Empty_o   = w_empty;
    assign fifoBus.p_Full_o    = w_full;
    assign fifoBus.p_Over_o    = r_over;
    assign fifoBus.FifoLevel_o = r_level;
    assign p_ParityErr_o       = r_done & r_donePe;
    assign p_FrameErr_o        = r_done & r_doneFe;
    assign ParityErrorNum_o    = r_parNum;
    assign FrameErrorNum_o     = r_frameNum;
    assign p_IdleGap_o         = r_gapPulse;
endmodule
`default_nettype wire

// File: tb/tb_rx_core_param.sv
`default_nettype none
// ============================================================================
// Module   : tb_rx_core_param
// Brief    : Self-checking bench for rx_core_param against a frame-level model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_rx_core_param;
    localparam int DW    = 8;
    localparam int OVS   = 16;
    localparam int AW    = 6;
    localparam int DEPTH = 64;

    logic       clk = 1'b0, rst = 1'b1, p_Enable_i = 1'b1, AcqSig_i = 1'b0, Rx_i = 1'b1;
    logic       p_ParityEnable_i = 1'b0, ParityMethod_i = 1'b0, p_BigEnd_i = 1'b0, StopBits_i = 1'b0;
    logic [7:0] IdleGapBits_i = 8'd0;
    logic       p_ParityErr_o, p_FrameErr_o, p_IdleGap_o;
    logic [7:0] ParityErrorNum_o, FrameErrorNum_o;

    rx_core_param_if #(.DATA_W(DW), .FIFO_AW(AW)) fifoIf ();

    rx_core_param #(.DATA_W(DW), .OVS(OVS), .FIFO_AW(AW)) dut (
        .clk              (clk),
        .rst              (rst),
        .p_Enable_i       (p_Enable_i),
        .AcqSig_i         (AcqSig_i),
        .Rx_i             (Rx_i),
        .p_ParityEnable_i (p_ParityEnable_i),
        .ParityMethod_i   (ParityMethod_i),
        .p_BigEnd_i       (p_BigEnd_i),
        .StopBits_i       (StopBits_i),
        .IdleGapBits_i    (IdleGapBits_i),
        .fifoBus          (fifoIf.slave),
        .p_ParityErr_o    (p_ParityErr_o),
        .p_FrameErr_o     (p_FrameErr_o),
        .ParityErrorNum_o (ParityErrorNum_o),
        .FrameErrorNum_o  (FrameErrorNum_o),
        .p_IdleGap_o      (p_IdleGap_o)
    );

    always #5 clk = ~clk;
    always @(negedge clk) AcqSig_i = ~AcqSig_i;

    int tests = 0, errs = 0;
    int parPulses = 0, framePulses = 0, gapPulses = 0, tickCnt = 0, lastGapTick = 0;
    logic [7:0] expQ[$];
    int  expPar = 0, expFrame = 0;
    logic expOver = 1'b0;

    always @(posedge clk) if (AcqSig_i) tickCnt++;
    always @(negedge clk) begin
        if (p_ParityErr_o) parPulses++;
        if (p_FrameErr_o)  framePulses++;
        if (p_IdleGap_o) begin gapPulses++; lastGapTick = tickCnt; end
    end

    function automatic int sat8(input int v);
        return (v > 255) ? 255 : v;
    endfunction

    task automatic tickWait();
        do @(posedge clk); while (AcqSig_i !== 1'b1);
        #1;
    endtask

    task automatic holdLine(input logic v, input int n);
        Rx_i = v;
        repeat (n) tickWait();
    endtask

    // Serialises one character and records what the receiver must do with it.
    task automatic sendFrame(input logic [7:0] d, input logic par, input logic odd, input logic big,
                             input logic two, input logic badPar, input logic badStop,
                             input int idleBits, output int stopTick);
        logic pbit;
        p_ParityEnable_i = par; ParityMethod_i = odd; p_BigEnd_i = big; StopBits_i = two;
        holdLine(1'b0, OVS);
        for (int i = 0; i < DW; i++) holdLine(big ? d[DW-1-i] : d[i], OVS);
        pbit = (^d) ^ odd ^ badPar;
        if (par) holdLine(pbit, OVS);
        if (two) holdLine(1'b1, OVS);
        stopTick = tickCnt;
        if (badStop) begin holdLine(1'b0, OVS/2 + 4); holdLine(1'b1, OVS/2 - 4); end
        else holdLine(1'b1, OVS);
        holdLine(1'b1, idleBits * OVS);
        if (par && badPar) expPar++;
        if (badStop) expFrame++;
        if (!(par && badPar) && !badStop) begin
            if (expQ.size() < DEPTH) expQ.push_back(d);
            else expOver = 1'b1;
        end
    endtask

    task automatic readWord(output logic [7:0] d);
        @(posedge clk); #1 fifoIf.n_Rd_i = 1'b0;
        @(posedge clk); #1 fifoIf.n_Rd_i = 1'b1;
        d = fifoIf.Data_o;
    endtask

    task automatic test_reset();
        fifoIf.n_Rd_i = 1'b1; fifoIf.n_Clr_i = 1'b1; rst = 1'b1;
        repeat (4) @(posedge clk); #1;
        tests++; if (fifoIf.Data_o !== 8'h00) begin errs++; $display("FAIL reset_data got %h want 00", fifoIf.Data_o); end
        tests++; if (fifoIf.p_Empty_o !== 1'b1) begin errs++; $display("FAIL reset_empty got %b want 1", fifoIf.p_Empty_o); end
        tests++; if (fifoIf.p_Full_o !== 1'b0 || fifoIf.p_Over_o !== 1'b0) begin errs++; $display("FAIL reset_full_over got %b%b want 00", fifoIf.p_Full_o, fifoIf.p_Over_o); end
        tests++; if (fifoIf.FifoLevel_o !== 7'd0) begin errs++; $display("FAIL reset_level got %0d want 0", fifoIf.FifoLevel_o); end
        tests++; if (ParityErrorNum_o !== 8'd0 || FrameErrorNum_o !== 8'd0) begin errs++; $display("FAIL reset_counts got %0d/%0d want 0/0", ParityErrorNum_o, FrameErrorNum_o); end
        tests++; if ({p_ParityErr_o, p_FrameErr_o, p_IdleGap_o} !== 3'b000) begin errs++; $display("FAIL reset_pulses got %b want 000", {p_ParityErr_o, p_FrameErr_o, p_IdleGap_o}); end
        rst = 1'b0;
        holdLine(1'b1, 2 * OVS);
    endtask

    task automatic test_basic();
        logic [7:0] d; int st;
        sendFrame(8'h55, 0, 0, 0, 0, 0, 0, 1, st);
        tests++; if (fifoIf.FifoLevel_o !== 7'(expQ.size())) begin errs++; $display("FAIL basic_level got %0d want %0d", fifoIf.FifoLevel_o, expQ.size()); end
        readWord(d);
        tests++; if (d !== expQ.pop_front()) begin errs++; $display("FAIL basic_data got %h want 55", d); end
        tests++; if (fifoIf.FifoLevel_o !== 7'd0) begin errs++; $display("FAIL basic_level_after got %0d want 0", fifoIf.FifoLevel_o); end
        tests++; if (parPulses != 0 || framePulses != 0) begin errs++; $display("FAIL basic_pulses got %0d/%0d want 0/0", parPulses, framePulses); end
    endtask

    task automatic test_parity();
        logic [7:0] d; int st;
        sendFrame(8'hA3, 1, 1, 1, 0, 0, 0, 1, st);
        readWord(d);
        tests++; if (d !== expQ.pop_front()) begin errs++; $display("FAIL parity_good_data got %h want a3", d); end
        sendFrame(8'hA3, 1, 1, 1, 0, 1, 0, 1, st);
        tests++; if (fifoIf.FifoLevel_o !== 7'(expQ.size())) begin errs++; $display("FAIL parity_bad_level got %0d want %0d", fifoIf.FifoLevel_o, expQ.size()); end
        tests++; if (parPulses != expPar) begin errs++; $display("FAIL parity_pulses got %0d want %0d", parPulses, expPar); end
        tests++; if (ParityErrorNum_o !== 8'(sat8(expPar))) begin errs++; $display("FAIL parity_count got %0d want %0d", ParityErrorNum_o, sat8(expPar)); end
    endtask

    task automatic test_framing();
        logic [7:0] d; int st;
        sendFrame(8'h3A, 0, 0, 0, 1, 0, 1, 1, st);
        tests++; if (FrameErrorNum_o !== 8'(sat8(expFrame))) begin errs++; $display("FAIL frame_count got %0d want %0d", FrameErrorNum_o, sat8(expFrame)); end
        tests++; if (framePulses != expFrame) begin errs++; $display("FAIL frame_pulses got %0d want %0d", framePulses, expFrame); end
        tests++; if (fifoIf.FifoLevel_o !== 7'(expQ.size())) begin errs++; $display("FAIL frame_level got %0d want %0d", fifoIf.FifoLevel_o, expQ.size()); end
        holdLine(1'b0, 4);
        holdLine(1'b1, 2 * OVS);
        sendFrame(8'h5A, 0, 0, 0, 0, 0, 0, 1, st);
        readWord(d);
        tests++; if (d !== expQ.pop_front()) begin errs++; $display("FAIL false_start_data got %h want 5a", d); end
        tests++; if (FrameErrorNum_o !== 8'(sat8(expFrame)) || ParityErrorNum_o !== 8'(sat8(expPar))) begin errs++; $display("FAIL false_start_counts got %0d/%0d want %0d/%0d", FrameErrorNum_o, ParityErrorNum_o, sat8(expFrame), sat8(expPar)); end
    endtask

    task automatic test_overflow();
        logic [7:0] d, w; int st;
        for (int i = 0; i <= DEPTH; i++) sendFrame(8'(i), 0, 0, 0, 0, 0, 0, 1, st);
        tests++; if (fifoIf.p_Full_o !== 1'b1) begin errs++; $display("FAIL ovf_full got %b want 1", fifoIf.p_Full_o); end
        tests++; if (fifoIf.FifoLevel_o !== 7'(expQ.size())) begin errs++; $display("FAIL ovf_level got %0d want %0d", fifoIf.FifoLevel_o, expQ.size()); end
        tests++; if (fifoIf.p_Over_o !== expOver) begin errs++; $display("FAIL ovf_over got %b want %b", fifoIf.p_Over_o, expOver); end
        readWord(d);
        w = expQ.pop_front();
        tests++; if (d !== w) begin errs++; $display("FAIL ovf_first got %h want %h", d, w); end
        @(posedge clk); #1 fifoIf.n_Clr_i = 1'b0;
        @(posedge clk); #1 fifoIf.n_Clr_i = 1'b1;
        expQ.delete(); expOver = 1'b0;
        tests++; if (fifoIf.FifoLevel_o !== 7'd0 || fifoIf.p_Empty_o !== 1'b1) begin errs++; $display("FAIL clr_level got %0d empty %b want 0/1", fifoIf.FifoLevel_o, fifoIf.p_Empty_o); end
        tests++; if (fifoIf.p_Over_o !== expOver) begin errs++; $display("FAIL clr_over got %b want 0", fifoIf.p_Over_o); end
        tests++; if (fifoIf.Data_o !== d) begin errs++; $display("FAIL clr_data_hold got %h want %h", fifoIf.Data_o, d); end
    endtask

    task automatic test_idle_gap();
        logic [7:0] d; int st, g0, want;
        IdleGapBits_i = 8'd3;
        g0 = gapPulses;
        sendFrame(8'h81, 0, 0, 0, 0, 0, 0, 0, st);
        holdLine(1'b1, 4 * OVS);
        tests++; if (gapPulses - g0 != 1) begin errs++; $display("FAIL gap_once got %0d want 1", gapPulses - g0); end
        want = st + OVS/2 + 3 * OVS;
        tests++; if (lastGapTick < want - 3 || lastGapTick > want + 3) begin errs++; $display("FAIL gap_time got %0d want %0d+-3", lastGapTick, want); end
        holdLine(1'b1, 3 * OVS);
        tests++; if (gapPulses - g0 != 1) begin errs++; $display("FAIL gap_disarm got %0d want 1", gapPulses - g0); end
        g0 = gapPulses;
        sendFrame(8'h18, 0, 0, 0, 0, 0, 0, 0, st);
        holdLine(1'b1, OVS + OVS/2);
        sendFrame(8'h24, 0, 0, 0, 0, 0, 0, 0, st);
        tests++; if (gapPulses != g0) begin errs++; $display("FAIL gap_early_start got %0d want 0", gapPulses - g0); end
        IdleGapBits_i = 8'd0;
        holdLine(1'b1, 5 * OVS);
        tests++; if (gapPulses != g0) begin errs++; $display("FAIL gap_disabled got %0d want 0", gapPulses - g0); end
        while (expQ.size() > 0) begin
            logic [7:0] w;
            readWord(d); w = expQ.pop_front();
            tests++; if (d !== w) begin errs++; $display("FAIL gap_data got %h want %h", d, w); end
        end
    endtask

    task automatic test_random();
        logic [7:0] d, w; int st;
        logic par, odd, big, two, bp, bs;
        for (int n = 0; n < 12; n++) begin
            par = 1'($urandom); odd = 1'($urandom); big = 1'($urandom); two = 1'($urandom);
            bp  = par && ($urandom_range(3) == 0);
            bs  = ($urandom_range(4) == 0);
            sendFrame(8'($urandom), par, odd, big, two, bp, bs, 1, st);
            tests++; if (fifoIf.FifoLevel_o !== 7'(expQ.size())) begin errs++; $display("FAIL rand_level[%0d] got %0d want %0d", n, fifoIf.FifoLevel_o, expQ.size()); end
            if (n % 3 == 2) begin
                while (expQ.size() > 0) begin
                    readWord(d); w = expQ.pop_front();
                    tests++; if (d !== w) begin errs++; $display("FAIL rand_data got %h want %h", d, w); end
                end
            end
        end
        tests++; if (ParityErrorNum_o !== 8'(sat8(expPar)) || parPulses != expPar) begin errs++; $display("FAIL rand_parity got %0d/%0d want %0d", ParityErrorNum_o, parPulses, expPar); end
        tests++; if (FrameErrorNum_o !== 8'(sat8(expFrame)) || framePulses != expFrame) begin errs++; $display("FAIL rand_frame got %0d/%0d want %0d", FrameErrorNum_o, framePulses, expFrame); end
    endtask

    task automatic test_reset_mid();
        logic [7:0] d; int st;
        holdLine(1'b0, OVS); holdLine(1'b1, OVS); holdLine(1'b0, OVS);
        rst = 1'b1; Rx_i = 1'b1;
        repeat (2) @(posedge clk); #1 rst = 1'b0;
        expQ.delete(); expPar = 0; expFrame = 0; expOver = 1'b0;
        parPulses = 0; framePulses = 0;
        holdLine(1'b1, OVS);
        sendFrame(8'h3C, 0, 0, 0, 0, 0, 0, 1, st);
        tests++; if (fifoIf.FifoLevel_o !== 7'(expQ.size())) begin errs++; $display("FAIL rstmid_level got %0d want %0d", fifoIf.FifoLevel_o, expQ.size()); end
        readWord(d);
        tests++; if (d !== expQ.pop_front()) begin errs++; $display("FAIL rstmid_data got %h want 3c", d); end
        tests++; if (ParityErrorNum_o !== 8'd0 || FrameErrorNum_o !== 8'd0) begin errs++; $display("FAIL rstmid_counts got %0d/%0d want 0/0", ParityErrorNum_o, FrameErrorNum_o); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_parity();
        test_framing();
        test_overflow();
        test_idle_gap();
        test_random();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, errs);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog expired after %0d ticks, limit reached", tickCnt);
        $fatal(1, "watchdog");
    end
endmodule
`default_nettype wire
